// File: rtl/mon_commit_sequencer.sv
// Retire-to-monitor scheduler: compacts retire lanes into a FIFO, drains in order.
// Define MON_SEQ_WDOG_EN to build the no-commit watchdog that drives error.
module mon_commit_sequencer #(
   parameter int IN_LANES  = 4,
   parameter int OUT_CH    = 2,
   parameter int DEPTH     = 8,
   parameter int PAYLOAD_W = 160,
   parameter int WDOG_CYC  = 10000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [IN_LANES-1:0]           in_valid,
   input  logic [IN_LANES-1:0]           in_halt,
   input  logic [IN_LANES*PAYLOAD_W-1:0] in_payload,
   output logic                          in_ready,
   output logic [OUT_CH-1:0]             out_valid,
   output logic [OUT_CH*64-1:0]          out_order,
   output logic [OUT_CH-1:0]             out_halt,
   output logic [OUT_CH*PAYLOAD_W-1:0]   out_payload,
   output logic                          done,
   output logic                          error
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t               state, state_nx;
   logic [PAYLOAD_W-1:0] mem_pl [DEPTH];
   logic [DEPTH-1:0]     mem_halt;
   logic [AW-1:0]        head, tail;
   logic [CW-1:0]        count, count_nx, n_in, k;
   logic [63:0]          order_cnt;

   logic                 accept, in_stop, halt_out;
   logic [IN_LANES-1:0]  lane_wr;
   logic [AW-1:0]        lane_slot [IN_LANES];
   logic [OUT_CH-1:0]    take;
   logic [AW-1:0]        rd_slot [OUT_CH];

   assign accept = in_ready && (|in_valid);

   // Squeeze valid lanes onto consecutive tail slots; stop after a halt lane.
   always_comb begin
      n_in    = '0;
      in_stop = 1'b0;
      lane_wr = '0;
      for (int i = 0; i < IN_LANES; i++) begin
         lane_slot[i] = tail + n_in[AW-1:0];
         if (accept && in_valid[i] && !in_stop) begin
            lane_wr[i] = 1'b1;
            n_in = n_in + CW'(1);
            if (in_halt[i]) in_stop = 1'b1;
         end
      end
   end

   always_comb begin
      k        = '0;
      halt_out = 1'b0;
      take     = '0;
      for (int j = 0; j < OUT_CH; j++) begin
         rd_slot[j] = head + AW'(j);
         if (state != ST_DONE && j < int'(count) && !halt_out) begin
            take[j] = 1'b1;
            k = k + CW'(1);
            if (mem_halt[rd_slot[j]]) halt_out = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      count_nx = count + n_in - k;
      if (in_stop) state_nx = ST_DRAIN;
      if (halt_out) begin
         state_nx = ST_DONE;
         count_nx = '0;
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < IN_LANES; i++) begin
         if (lane_wr[i]) begin
            mem_pl[lane_slot[i]]   <= in_payload[i*PAYLOAD_W +: PAYLOAD_W];
            mem_halt[lane_slot[i]] <= in_halt[i];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_RUN;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         order_cnt   <= '0;
         in_ready    <= 1'b0;
         out_valid   <= '0;
         out_order   <= '0;
         out_halt    <= '0;
         out_payload <= '0;
         done        <= 1'b0;
      end else begin
         state     <= state_nx;
         count     <= count_nx;
         order_cnt <= order_cnt + 64'(k);
         done      <= done | halt_out;
         in_ready  <= (state_nx == ST_RUN) &&
                      (count_nx <= CW'(DEPTH - IN_LANES));
         if (halt_out) begin
            head <= '0;
            tail <= '0;
         end else begin
            head <= head + k[AW-1:0];
            tail <= tail + n_in[AW-1:0];
         end
         for (int j = 0; j < OUT_CH; j++) begin
            out_valid[j] <= take[j];
            out_halt[j]  <= take[j] & mem_halt[rd_slot[j]];
            out_order[j*64 +: 64] <= take[j] ? order_cnt + 64'(j) : '0;
            out_payload[j*PAYLOAD_W +: PAYLOAD_W] <=
               take[j] ? mem_pl[rd_slot[j]] : '0;
         end
      end
   end

`ifdef MON_SEQ_WDOG_EN
   localparam int WW = $clog2(WDOG_CYC + 1);
   logic [WW-1:0] wdog;

   // Saturates at the limit so the sticky flag never needs the counter again.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog  <= '0;
         error <= 1'b0;
      end else if (k != '0) begin
         wdog <= '0;
      end else if (state != ST_DONE && wdog != WW'(WDOG_CYC)) begin
         wdog <= wdog + WW'(1);
         if (wdog + WW'(1) == WW'(WDOG_CYC)) error <= 1'b1;
      end
   end
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_mon_commit_sequencer.sv
// Bench for mon_commit_sequencer: queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_mon_commit_sequencer;
   localparam int IL = 4;
   localparam int OC = 2;
   localparam int DP = 8;
   localparam int PW = 160;
   localparam int WD = 16;
`ifdef MON_SEQ_WDOG_EN
   localparam bit WDEN = 1'b1;
`else
   localparam bit WDEN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [IL-1:0]    in_valid = '0;
   logic [IL-1:0]    in_halt = '0;
   logic [IL*PW-1:0] in_payload = '0;
   logic             in_ready;
   logic [OC-1:0]    out_valid, out_halt;
   logic [OC*64-1:0] out_order;
   logic [OC*PW-1:0] out_payload;
   logic             done, error;

   mon_commit_sequencer #(
      .IN_LANES(IL), .OUT_CH(OC), .DEPTH(DP),
      .PAYLOAD_W(PW), .WDOG_CYC(WD)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_halt(in_halt), .in_payload(in_payload),
      .in_ready(in_ready), .out_valid(out_valid), .out_order(out_order),
      .out_halt(out_halt), .out_payload(out_payload),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] pl;
      bit            halt;
   } rec_t;

   typedef struct {
      longint unsigned ord;
      logic [PW-1:0]   pl;
      bit              halt;
      bit              dn;
      int              cyc;
   } log_t;

   rec_t            mq[$];
   log_t            lg[$];
   int              m_st;
   longint unsigned m_ord;
   int              m_wd;
   bit              m_err, m_done, m_rdy;
   bit              e_v[OC];
   bit              e_h[OC];
   longint unsigned e_ord[OC];
   logic [PW-1:0]   e_pl[OC];
   int              max_cnt = 0;
   int              cyc = 0;
   int              checks = 0;
   int              errors = 0;

   task automatic chk(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Model: program-order queue; state 0=run, 1=drain, 2=done.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         m_st = 0; m_ord = 0; m_wd = 0;
         m_err = 0; m_done = 0; m_rdy = 0;
         for (int j = 0; j < OC; j++) begin
            e_v[j] = 0; e_h[j] = 0; e_ord[j] = 0; e_pl[j] = '0;
         end
      end else begin
         bit   acc;
         int   n, pre;
         rec_t r;
         pre = m_st;
         acc = m_rdy && (in_valid != '0);
         for (int j = 0; j < OC; j++) begin
            e_v[j] = 0; e_h[j] = 0; e_ord[j] = 0; e_pl[j] = '0;
         end
         n = 0;
         if (pre != 2) begin
            for (int j = 0; j < OC; j++) begin
               if (mq.size() == 0) break;
               r = mq.pop_front();
               e_v[j] = 1; e_h[j] = r.halt; e_pl[j] = r.pl;
               e_ord[j] = m_ord + 64'(j);
               n++;
               if (r.halt) begin
                  m_st = 2; m_done = 1; mq.delete();
                  break;
               end
            end
         end
         if (acc) begin
            for (int i = 0; i < IL; i++) begin
               if (in_valid[i]) begin
                  r.pl = in_payload[i*PW +: PW];
                  r.halt = in_halt[i];
                  mq.push_back(r);
                  if (in_halt[i]) begin
                     m_st = 1;
                     break;
                  end
               end
            end
         end
         m_ord += 64'(n);
         if (pre != 2) begin
            if (n == 0) begin
               if (m_wd < WD) m_wd++;
               if (m_wd == WD) m_err = 1;
            end else begin
               m_wd = 0;
            end
         end
         m_rdy = (m_st == 0) && (DP - mq.size() >= IL);
         if (mq.size() > max_cnt) max_cnt = mq.size();
      end
   end

   // Compare process: every cycle, 1ns after the edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      chk("in_ready", in_ready, m_rdy);
      chk("done", done, m_done);
      chk("error", error, WDEN & m_err);
      for (int j = 0; j < OC; j++) begin
         chk($sformatf("valid%0d", j), out_valid[j], e_v[j]);
         chk($sformatf("halt%0d", j), out_halt[j], e_h[j]);
         chk($sformatf("payload%0d", j), out_payload[j*PW +: PW], e_pl[j]);
         if (e_v[j] || !rst)
            chk($sformatf("order%0d", j), out_order[j*64 +: 64], e_ord[j]);
         if (out_valid[j])
            lg.push_back('{out_order[j*64 +: 64], out_payload[j*PW +: PW],
                           out_halt[j], done, cyc});
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid = '0;
      in_halt = '0;
      step();
      step();
      rst = 1'b1;
      lg.delete();
      max_cnt = 0;
   endtask

   task automatic send_beat(input logic [IL-1:0] v, input logic [IL-1:0] h,
                            input logic [IL*PW-1:0] pl);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         step();
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout actual=0 required=1");
      end else begin
         in_valid = v;
         in_halt = h;
         in_payload = pl;
         step();
         in_valid = '0;
         in_halt = '0;
      end
   endtask

   function automatic logic [IL*PW-1:0] tags(input int base);
      logic [IL*PW-1:0] p;
      for (int i = 0; i < IL; i++) p[i*PW +: PW] = PW'(base + i);
      return p;
   endfunction

   initial begin
      logic [IL*PW-1:0] pl;
      logic [PW-1:0]    a, b;
      int               bad;

      // Reset state
      rst = 1'b0;
      step();
      chk("rst_ctl", {in_ready, out_valid, out_halt, done, error}, '0);
      chk("rst_order", out_order, '0);
      chk("rst_payload", out_payload, '0);
      do_reset();

      // Three full beats: orders 0..11 in lane order, in_ready drops
      for (int bt = 0; bt < 3; bt++) begin
         send_beat(4'hF, 4'h0, tags(bt * 4));
         if (bt == 1) chk("t1_ready_drop", in_ready, 1'b0);
      end
      repeat (8) step();
      chk("t1_count", lg.size(), 12);
      for (int i = 0; i < lg.size(); i++) begin
         chk("t1_ord", lg[i].ord, i);
         chk("t1_pl", lg[i].pl, i);
      end

      // Sparse beat 1010: A then B on channels 0/1 in one cycle
      lg.delete();
      a = {5{32'hAAAA_0001}};
      b = {5{32'hBBBB_0003}};
      pl = '0;
      pl[1*PW +: PW] = a;
      pl[3*PW +: PW] = b;
      send_beat(4'b1010, 4'h0, pl);
      repeat (4) step();
      chk("t2_count", lg.size(), 2);
      if (lg.size() == 2) begin
         chk("t2_a", lg[0].pl, a);
         chk("t2_b", lg[1].pl, b);
         chk("t2_ord_a", lg[0].ord, 12);
         chk("t2_ord_b", lg[1].ord, 13);
         chk("t2_same_cyc", lg[1].cyc, lg[0].cyc);
      end

      // Halt on lane 1 drops lanes 2,3
      lg.delete();
      send_beat(4'hF, 4'b0010, tags(100));
      for (int i = 0; i < 4; i++) begin
         chk("t3_ready", in_ready, 1'b0);
         in_valid = 4'hF;
         step();
      end
      in_valid = '0;
      repeat (3) step();
      chk("t3_count", lg.size(), 2);
      if (lg.size() == 2) begin
         chk("t3_pl0", lg[0].pl, 100);
         chk("t3_pl1", lg[1].pl, 101);
         chk("t3_halt", lg[1].halt, 1'b1);
         chk("t3_ord", lg[1].ord, 15);
         chk("t3_done_edge", lg[1].dn, 1'b1);
      end
      chk("t3_done", done, 1'b1);
      chk("t3_quiet", out_valid, '0);

      // Sustained full beats across pointer wrap
      do_reset();
      in_valid = 4'hF;
      for (int i = 0; i < 40; i++) begin
         in_payload = tags(1000 + i * 4);
         step();
      end
      in_valid = '0;
      repeat (6) step();
      bad = 0;
      for (int i = 0; i < lg.size(); i++)
         if (lg[i].ord != longint'(i)) bad++;
      chk("t4_mono", bad, 0);
      chk("t4_cnt", max_cnt <= DP, 1'b1);
      chk("t4_tput", lg.size() >= 70, 1'b1);

      // Reset with 5 records held
      do_reset();
      send_beat(4'b0111, 4'h0, tags(200));
      send_beat(4'hF, 4'h0, tags(300));
      chk("t6_fill", mq.size(), 5);
      rst = 1'b0;
      #1;
      chk("t6_ctl", {in_ready, out_valid, out_halt, done, error}, '0);
      chk("t6_order", out_order, '0);
      chk("t6_payload", out_payload, '0);
      step();
      rst = 1'b1;
      lg.delete();
      send_beat(4'b0001, 4'h0, tags(77));
      repeat (3) step();
      chk("t6_count", lg.size(), 1);
      if (lg.size() == 1) begin
         chk("t6_ord0", lg[0].ord, 0);
         chk("t6_pl", lg[0].pl, 77);
      end

      // Watchdog: no beats after reset release
      do_reset();
      repeat (15) step();
      chk("t5_err15", error, 1'b0);
      step();
      chk("t5_err16", error, WDEN);
      repeat (5) step();
      chk("t5_sticky", error, WDEN);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 2500; c++) begin
         if (done && $urandom_range(0, 3) == 0) begin
            do_reset();
         end else if ($urandom_range(0, 499) == 0) begin
            rst = 1'b0;
            step();
            rst = 1'b1;
         end
         in_valid = IL'($urandom);
         for (int i = 0; i < IL; i++) begin
            in_halt[i] = ($urandom_range(0, 59) == 0);
            in_payload[i*PW +: PW] = {$urandom, $urandom, $urandom,
                                     $urandom, $urandom};
         end
         step();
      end
      in_valid = '0;
      in_halt = '0;
      repeat (4) step();
      chk("rand_cnt", max_cnt <= DP, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
